alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Multi-cycle multiply/divide responder on the ALU request path.
- Consumes alu_in_pkt_t requests carrying MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Owns the architectural HI/LO registers and returns one alu_out_pkt_t completion per accepted request.
- Sits beside the single-cycle ALU in EX; the pipeline stalls on in_ready/busy.

Parameters:
- DATA_W, 32, operand/result width; HI and LO are DATA_W each.
- TAG_W, 4, width of the request tag echoed in the completion.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- alu_in_pkt  input  alu_in_pkt_t  request: valid, op (alu_op_t), src_a, src_b (DATA_W), tag (TAG_W)
- in_ready  output  1  request accepted when alu_in_pkt.valid && in_ready
- alu_out_pkt  output  alu_out_pkt_t  completion: valid, wb_en, result (DATA_W), tag
- out_ready  input  1  consumer takes completion when alu_out_pkt.valid && out_ready
- flush  input  1  abandon in-flight op (pipeline squash)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn low):
  - State = IDLE; HI = LO = 0.
  - alu_out_pkt = '0 (valid = 0); in_ready = 1; busy = 0.
- FSM states IDLE, CALC, FIX, RESP. in_ready = (state == IDLE) && !flush.
- IDLE, accept with op MFHI/MFLO:
  - Capture result = HI/LO, tag, wb_en = 1; go to RESP.
  - alu_out_pkt.valid is high the next cycle (latency 1).
- IDLE, accept with op MTHI/MTLO:
  - HI/LO <= src_a at the accept edge; capture wb_en = 0; go to RESP (latency 1).
- IDLE, accept with op MULT/MULTU/DIV/DIVU:
  - Latch operands. Signed ops convert both operands to magnitude and record the result signs.
  - Load counter = DATA_W; go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring subtract-shift.
  - Counter decrements each step; go to FIX when counter reaches 1.
- FIX:
  - Apply sign correction. Signed DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO: MULT gives HI = upper product, LO = lower product. DIV gives LO = quotient, HI = remainder.
  - Capture wb_en = 0, result = LO; go to RESP.
  - Completion valid DATA_W+2 cycles after acceptance.
- Divide by zero: no trap. LO = all ones, HI = dividend (src_a unmodified). Same DATA_W+2 latency.
- Signed overflow (DIV of 0x8000_0000 by 0xFFFF_FFFF): LO = 0x8000_0000, HI = 0, via the natural magnitude path.
- RESP:
  - alu_out_pkt.valid = 1; payload held stable until out_ready.
  - On out_ready: valid clears and the FSM goes to IDLE.
  - A new request is not accepted in the same cycle (one bubble between ops).
- flush (any state):
  - Next state = IDLE; alu_out_pkt.valid = 0 next cycle.
  - In-progress CALC result is discarded; HI/LO are unchanged unless FIX had already completed.
  - flush in the same cycle as alu_in_pkt.valid means flush wins and the request is not accepted.
  - flush in the same cycle as FIX means the HI/LO write is suppressed.
- Unsupported op code accepted in IDLE: completion with wb_en = 0, result = 0, latency 1. HI/LO untouched.
- resetn deassertion mid-operation: no partial state survives; HI/LO = 0.

Decomposition:
- alu_pkg holds:
  - alu_op_t enum, adding OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO.
  - alu_in_pkt_t and alu_out_pkt_t structs.
  - muldiv_state_t enum {IDLE, CALC, FIX, RESP}.
  - MULDIV_LAT = DATA_W+2 constant.
- One sub-module, alu_muldiv_core: the iterative datapath (accumulator, shift, subtract, counter, sign fix), started by a start pulse and reporting done.
- The top level keeps the FSM, handshakes, HI/LO and flush.

Test Plan:
- MULT src_a=0xFFFF_FFFE (-2), src_b=3, out_ready=1 -> completion at cycle 34, wb_en=0. Then MFHI gives 0xFFFF_FFFF and MFLO gives 0xFFFF_FFFA.
- DIVU src_a=100, src_b=7 -> LO=14, HI=2. DIV src_a=-7, src_b=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
- DIV src_a=0x1234, src_b=0 -> LO=0xFFFF_FFFF, HI=0x1234, latency 34. DIV 0x8000_0000 by -1 -> LO=0x8000_0000, HI=0.
- MTHI 0xDEAD_BEEF, then MFHI, with out_ready held low 5 cycles -> alu_out_pkt stable with result 0xDEAD_BEEF, tag echoed. in_ready=0 until the handshake completes.
- MULTU issued, flush asserted at CALC cycle 10 -> no completion, busy=0 next cycle. Then MFLO returns the prior LO value.
- resetn pulsed low during CALC -> valid=0 immediately, HI=LO=0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// alu_muldiv_pkg
// Shared types and constants for the multi-cycle multiply/divide responder.
//   DATA_W      operand / result width (HI and LO are DATA_W each)
//   TAG_W       width of the request tag echoed in the completion
//   MULDIV_LAT  cycles from accept to completion for MULT/MULTU/DIV/DIVU
//   alu_op_t    ALU op codes; the muldiv unit serves the upper eight
//   alu_in_pkt_t / alu_out_pkt_t  request and completion payloads
//   muldiv_state_t  control FSM states
// -----------------------------------------------------------------------------
package alu_muldiv_pkg;

  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;
  localparam int MULDIV_LAT = DATA_W + 2;
  // Step counter must hold the value DATA_W itself.
  localparam int CNT_W      = $clog2(DATA_W + 1);

  // Ops 0..7 belong to the single-cycle ALU; this unit answers them with an
  // empty completion.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_MULT  = 4'd8,
    OP_MULTU = 4'd9,
    OP_DIV   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_MFHI  = 4'd12,
    OP_MFLO  = 4'd13,
    OP_MTHI  = 4'd14,
    OP_MTLO  = 4'd15
  } alu_op_t;

  typedef struct packed {
    logic              valid;
    alu_op_t           op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [TAG_W-1:0]  tag;
  } alu_in_pkt_t;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
  } alu_out_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } muldiv_state_t;

  // True for the ops that run through the iterative datapath.
  function automatic logic is_muldiv_op(alu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Two's-complement negate when neg is set (magnitude / sign restore).
  function automatic logic [DATA_W-1:0] cond_neg(logic [DATA_W-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_if
// Request/completion handshake bundle between the EX stage and alu_muldiv.
//   alu_in_pkt   request (valid, op, src_a, src_b, tag)       master -> slave
//   in_ready     request accepted when valid && in_ready      slave  -> master
//   alu_out_pkt  completion (valid, wb_en, result, tag)        slave  -> master
//   out_ready    completion taken when valid && out_ready      master -> slave
// -----------------------------------------------------------------------------
interface alu_muldiv_if;
  import alu_muldiv_pkg::*;

  alu_in_pkt_t  alu_in_pkt;
  logic         in_ready;
  alu_out_pkt_t alu_out_pkt;
  logic         out_ready;

  modport master (
    output alu_in_pkt,
    output out_ready,
    input  in_ready,
    input  alu_out_pkt
  );

  modport slave (
    input  alu_in_pkt,
    input  out_ready,
    output in_ready,
    output alu_out_pkt
  );

endinterface

// File: rtl/alu_muldiv_core.sv
// -----------------------------------------------------------------------------
// alu_muldiv_core
// Iterative radix-2 multiply / restoring divide datapath.
//   clk, resetn   clock, asynchronous active-low reset
//   abort         drop the operation in progress (no done will follow)
//   start         load op/operands and begin DATA_W steps
//   op            MULT/MULTU/DIV/DIVU, sampled with start
//   src_a, src_b  operands, sampled with start
//   done          high during the cycle of the last step
//   res_hi/res_lo sign-corrected HI/LO; valid from the cycle after done until
//                 the next start
// Signed operands are converted to magnitudes at start, so the step logic is
// unsigned only; signs are reapplied on the result side.
// -----------------------------------------------------------------------------
module alu_muldiv_core
  import alu_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              abort,
  input  logic              start,
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  alu_op_t             op_q,    op_d;
  logic [DATA_W-1:0]   a_q,     a_d;      // raw dividend, returned as HI on /0
  logic [DATA_W-1:0]   opnd_q,  opnd_d;   // multiplicand or divisor magnitude
  logic [2*DATA_W-1:0] acc_q,   acc_d;    // {upper, lower} working register
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                run_q,   run_d;
  logic                neg_q,   neg_d;    // negate product / quotient
  logic                rneg_q,  rneg_d;   // negate remainder (dividend sign)
  logic                dz_q,    dz_d;     // divide by zero

  // ---- operand preparation at start ----
  logic              in_is_mul, in_signed, sgn_a, sgn_b;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign in_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sgn_a     = in_signed & src_a[DATA_W-1];
  assign sgn_b     = in_signed & src_b[DATA_W-1];
  assign mag_a     = cond_neg(src_a, sgn_a);
  assign mag_b     = cond_neg(src_b, sgn_b);

  // ---- one multiply step ----
  // Lower half holds the not-yet-consumed multiplier bits; each step adds the
  // multiplicand into the upper half when the current bit is set, then shifts
  // the whole accumulator right with the carry entering at the top.
  logic                is_mul_q;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;

  assign is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // ---- one restoring divide step ----
  // Upper half is the partial remainder, lower half the dividend bits that
  // turn into quotient bits as they shift out. The trial difference is one
  // bit wider so its top bit is the borrow.
  logic [DATA_W:0]     div_shift, div_diff;
  logic [2*DATA_W-1:0] div_next;

  assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[DATA_W]
                   ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                   : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};

  assign done = run_q && (cnt_q == CNT_W'(1));

  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      op_d   = op;
      a_d    = src_a;
      neg_d  = sgn_a ^ sgn_b;
      rneg_d = sgn_a;
      dz_d   = !in_is_mul && (src_b == '0);
      opnd_d = in_is_mul ? mag_a : mag_b;
      acc_d  = {{DATA_W{1'b0}}, (in_is_mul ? mag_b : mag_a)};
      cnt_d  = CNT_W'(DATA_W);
      run_d  = 1'b1;
    end else if (run_q) begin
      acc_d = is_mul_q ? mul_next : div_next;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  // ---- sign correction ----
  // The 0x8000_0000 / -1 case needs no special handling: the magnitude
  // quotient 0x8000_0000 negates to itself.
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem;

  assign prod = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo  = cond_neg(acc_q[DATA_W-1:0], neg_q);
  assign rem  = cond_neg(acc_q[2*DATA_W-1:DATA_W], rneg_q);

  // Divide by zero does not trap: LO saturates to all ones, HI returns the
  // untouched dividend.
  assign res_hi = is_mul_q ? prod[2*DATA_W-1:DATA_W] : (dz_q ? a_q : rem);
  assign res_lo = is_mul_q ? prod[DATA_W-1:0]        : (dz_q ? {DATA_W{1'b1}} : quo);

endmodule

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Multi-cycle multiply/divide responder beside the single-cycle ALU in EX.
// Owns the architectural HI/LO pair and returns exactly one completion per
// accepted request (unless squashed by flush or reset).
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     alu_muldiv_if.slave: alu_in_pkt/in_ready request handshake,
//           alu_out_pkt/out_ready completion handshake
//   flush   pipeline squash: abandon whatever is in flight, return to IDLE
//   busy    high whenever the FSM is not IDLE
// Latency: MFHI/MFLO/MTHI/MTLO/unsupported = 1, MULT/MULTU/DIV/DIVU =
// MULDIV_LAT. The completion stays in RESP (payload stable) until out_ready,
// and the unit leaves one idle cycle between operations.
// -----------------------------------------------------------------------------
module alu_muldiv
  import alu_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  alu_muldiv_if.slave     bus,
  input  logic            flush,
  output logic            busy
);

  muldiv_state_t     state_q, state_d;
  logic [DATA_W-1:0] hi_q,    hi_d;
  logic [DATA_W-1:0] lo_q,    lo_d;
  alu_out_pkt_t      out_q,   out_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;

  logic              accept;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_hi, core_lo;

  // flush beats a simultaneous request.
  assign bus.in_ready    = (state_q == IDLE) && !flush;
  assign accept          = bus.alu_in_pkt.valid && bus.in_ready;
  assign core_start      = accept && is_muldiv_op(bus.alu_in_pkt.op);
  assign bus.alu_out_pkt = out_q;
  assign busy            = (state_q != IDLE);

  alu_muldiv_core u_core (
    .clk    (clk),
    .resetn (resetn),
    .abort  (flush),
    .start  (core_start),
    .op     (bus.alu_in_pkt.op),
    .src_a  (bus.alu_in_pkt.src_a),
    .src_b  (bus.alu_in_pkt.src_b),
    .done   (core_done),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    tag_d   = tag_q;

    if (flush) begin
      // Squash: any pending HI/LO write from FIX is dropped with the rest.
      state_d = IDLE;
      out_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_d        = bus.alu_in_pkt.tag;
            out_d.valid  = 1'b1;
            out_d.wb_en  = 1'b0;
            out_d.result = '0;
            out_d.tag    = bus.alu_in_pkt.tag;
            state_d      = RESP;
            case (bus.alu_in_pkt.op)
              OP_MFHI: begin
                out_d.wb_en  = 1'b1;
                out_d.result = hi_q;
              end
              OP_MFLO: begin
                out_d.wb_en  = 1'b1;
                out_d.result = lo_q;
              end
              OP_MTHI: hi_d = bus.alu_in_pkt.src_a;
              OP_MTLO: lo_d = bus.alu_in_pkt.src_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                out_d.valid = 1'b0;
                state_d     = CALC;
              end
              default: ;  // unsupported op: empty completion
            endcase
          end
        end

        CALC: begin
          if (core_done) begin
            state_d = FIX;
          end
        end

        FIX: begin
          hi_d         = core_hi;
          lo_d         = core_lo;
          out_d.valid  = 1'b1;
          out_d.wb_en  = 1'b0;
          out_d.result = core_lo;
          out_d.tag    = tag_q;
          state_d      = RESP;
        end

        RESP: begin
          if (bus.out_ready) begin
            out_d.valid = 1'b0;
            state_d     = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
// Drives alu_muldiv with directed and random requests. Expected completions
// come from a 64-bit arithmetic model of HI/LO; a negedge monitor compares
// busy, in_ready and every valid completion against that model.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic flush  = 1'b0;
  logic busy;

  alu_muldiv_if bus();

  alu_muldiv dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .flush  (flush),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              wb_en;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    bit                chk_res;
  } exp_t;

  exp_t              exp_q[$];
  bit                pending = 1'b0;
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] m_hi = '0;
  logic [DATA_W-1:0] m_lo = '0;
  logic [DATA_W-1:0] last_result;
  int                last_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural reference: HI/LO effect, completion payload and latency.
  function automatic void model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo,
                                output logic wb, output logic [31:0] res,
                                output bit chk, output int lat);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    nhi = hi; nlo = lo; wb = 1'b0; res = '0; chk = 1'b1; lat = 1;
    case (op)
      OP_MFHI: begin wb = 1'b1; res = hi; end
      OP_MFLO: begin wb = 1'b1; res = lo; end
      OP_MTHI: begin nhi = a; chk = 1'b0; end
      OP_MTLO: begin nlo = a; chk = 1'b0; end
      OP_MULT: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        nhi = sp[63:32]; nlo = sp[31:0]; res = nlo; lat = MULDIV_LAT;
      end
      OP_MULTU: begin
        ua = 64'(a); ub = 64'(b); up = ua * ub;
        nhi = up[63:32]; nlo = up[31:0]; res = nlo; lat = MULDIV_LAT;
      end
      OP_DIV: begin
        if (b == 0) begin nlo = '1; nhi = a; end
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          sq = sa / sb; sr = sa % sb; nlo = sq[31:0]; nhi = sr[31:0];
        end
        res = nlo; lat = MULDIV_LAT;
      end
      OP_DIVU: begin
        if (b == 0) begin nlo = '1; nhi = a; end
        else begin
          ua = 64'(a); ub = 64'(b); uq = ua / ub; ur = ua % ub;
          nlo = uq[31:0]; nhi = ur[31:0];
        end
        res = nlo; lat = MULDIV_LAT;
      end
      default: ;
    endcase
  endfunction

  // Monitor: every cycle out of reset.
  always @(negedge clk) begin
    if (resetn) begin
      check("busy", 64'(busy), 64'(pending));
      check("in_ready", 64'(bus.in_ready), 64'(!pending && !flush));
      if (bus.alu_out_pkt.valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: got valid=1 result=0x%0h, expected valid=0 (cycle %0d)",
                   bus.alu_out_pkt.result, cyc);
        end else begin
          check("wb_en", 64'(bus.alu_out_pkt.wb_en), 64'(exp_q[0].wb_en));
          check("tag", 64'(bus.alu_out_pkt.tag), 64'(exp_q[0].tag));
          if (exp_q[0].chk_res)
            check("result", 64'(bus.alu_out_pkt.result), 64'(exp_q[0].result));
        end
      end
    end
  end

  // Present one request, wait (bounded) for its completion, hold out_ready low
  // for 'hold' cycles, then take it and commit the model.
  task automatic do_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] nhi, nlo, res;
    logic        wb;
    bit          chk, seen;
    int          lat, t0;
    exp_t        e;
    model(op, a, b, m_hi, m_lo, nhi, nlo, wb, res, chk, lat);
    e.tag = TAG_W'($urandom); e.wb_en = wb; e.result = res; e.chk_res = chk;
    bus.alu_in_pkt.valid = 1'b1;
    bus.alu_in_pkt.op    = op;
    bus.alu_in_pkt.src_a = a;
    bus.alu_in_pkt.src_b = b;
    bus.alu_in_pkt.tag   = e.tag;
    @(posedge clk); #1;
    exp_q.push_back(e);
    pending = 1'b1;
    t0 = cyc;
    bus.alu_in_pkt.valid = 1'b0;
    bus.alu_in_pkt.src_a = $urandom;
    bus.alu_in_pkt.src_b = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.alu_out_pkt.valid) seen = 1'b1;
    end
    check("completion_seen", 64'(seen), 64'd1);
    if (!seen) begin
      exp_q.delete();
      pending = 1'b0;
      return;
    end
    last_lat = cyc - t0 + 1;  // counted from the accept cycle
    check("latency", 64'(last_lat), 64'(lat));
    repeat (hold) @(negedge clk);
    last_result   = bus.alu_out_pkt.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    pending = 1'b0;
    m_hi = nhi;
    m_lo = nlo;
    $display("op=%s a=0x%08h b=0x%08h tag=%0d -> result=0x%08h lat=%0d HI=0x%08h LO=0x%08h",
             op.name(), a, b, e.tag, last_result, last_lat, m_hi, m_lo);
  endtask

  // Start an iterative op and flush it 'dly' cycles after the accept edge.
  task automatic do_abort(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input int dly);
    bus.alu_in_pkt.valid = 1'b1;
    bus.alu_in_pkt.op    = op;
    bus.alu_in_pkt.src_a = a;
    bus.alu_in_pkt.src_b = b;
    bus.alu_in_pkt.tag   = TAG_W'($urandom);
    @(posedge clk); #1;
    pending = 1'b1;
    bus.alu_in_pkt.valid = 1'b0;
    repeat (dly) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush   = 1'b0;
    pending = 1'b0;
    $display("op=%s a=0x%08h b=0x%08h flushed %0d cycles after accept", op.name(), a, b, dly);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish before 2 ms");
    $fatal(1);
  end

  initial begin
    alu_op_t op;
    bus.alu_in_pkt = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(bus.alu_out_pkt.valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_latency_34", 64'(last_lat), 64'd34);
    check("mult_lo", 64'(last_result), 64'hFFFF_FFFA);
    do_op(OP_MFHI, 0, 0, 0);  check("mult_mfhi", 64'(last_result), 64'hFFFF_FFFF);
    do_op(OP_MFLO, 0, 0, 0);  check("mult_mflo", 64'(last_result), 64'hFFFF_FFFA);
    check("mf_latency_1", 64'(last_lat), 64'd1);

    do_op(OP_DIVU, 32'd100, 32'd7, 1);  check("divu_lo", 64'(last_result), 64'd14);
    do_op(OP_MFHI, 0, 0, 0);            check("divu_hi", 64'(last_result), 64'd2);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0); check("div_lo", 64'(last_result), 64'hFFFF_FFFD);
    do_op(OP_MFHI, 0, 0, 0);            check("div_hi", 64'(last_result), 64'hFFFF_FFFF);
    do_op(OP_DIV, 32'h1234, 32'd0, 0);  check("div0_lo", 64'(last_result), 64'hFFFF_FFFF);
    check("div0_latency", 64'(last_lat), 64'd34);
    do_op(OP_MFHI, 0, 0, 0);            check("div0_hi", 64'(last_result), 64'h1234);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0); check("ovf_lo", 64'(last_result), 64'h8000_0000);
    do_op(OP_MFHI, 0, 0, 0);            check("ovf_hi", 64'(last_result), 64'h0);

    do_op(OP_MTHI, 32'hDEAD_BEEF, 0, 0);
    do_op(OP_MFHI, 0, 0, 5);            check("mthi_mfhi_held", 64'(last_result), 64'hDEAD_BEEF);
    do_op(OP_MTLO, 32'h0BAD_F00D, 0, 2);

    do_abort(OP_MULTU, $urandom, $urandom, 10);
    do_op(OP_MFLO, 0, 0, 0);            check("flush_calc_lo", 64'(last_result), 64'h0BAD_F00D);
    do_abort(OP_DIV, 32'h7777_0000, 32'd3, 32);  // flush lands on the FIX cycle
    do_op(OP_MFHI, 0, 0, 0);            check("flush_fix_hi", 64'(last_result), 64'hDEAD_BEEF);
    do_op(OP_MFLO, 0, 0, 0);            check("flush_fix_lo", 64'(last_result), 64'h0BAD_F00D);

    // flush together with a request: the request must not be taken
    bus.alu_in_pkt.valid = 1'b1;
    bus.alu_in_pkt.op    = OP_MTHI;
    bus.alu_in_pkt.src_a = 32'h1111_1111;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.alu_in_pkt.valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    do_op(OP_MFHI, 0, 0, 0);            check("flush_wins_hi", 64'(last_result), 64'hDEAD_BEEF);

    do_op(OP_ADD, 32'd5, 32'd6, 1);     check("unsupported_res", 64'(last_result), 64'h0);

    for (int i = 0; i < 40; i++) begin
      op = alu_op_t'(4'($urandom_range(0, 15)));
      do_op(op, pick(), pick(), $urandom_range(0, 3));
    end

    // Reset in the middle of a divide.
    do_op(OP_MTLO, 32'h5555_AAAA, 0, 0);
    bus.alu_in_pkt.valid = 1'b1;
    bus.alu_in_pkt.op    = OP_DIVU;
    bus.alu_in_pkt.src_a = 32'd1000;
    bus.alu_in_pkt.src_b = 32'd9;
    @(posedge clk); #1;
    pending = 1'b1;
    bus.alu_in_pkt.valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.alu_out_pkt.valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    pending = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    do_op(OP_MFHI, 0, 0, 0);            check("rst_hi_zero", 64'(last_result), 64'h0);
    do_op(OP_MFLO, 0, 0, 0);            check("rst_lo_zero", 64'(last_result), 64'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
